axi_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream AXI4 write path (AW, W, B) between NUM_MASTERS upstream write masters.
- Grants one master at a time and holds the grant for the whole transaction: AW handshake, all W beats through WLAST, then the B handshake.
- Sits between VIP/DUT master ports and a single AXI4 slave port. Bus widths come from the axi_defs package.

---
 rtl/axi_wr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin share of one AXI4 write path (AW/W/B).
// Optional sticky beat_err output when AXI_WR_ARB_BEAT_CHECK_EN is defined.
package axi_defs;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
    parameter int ID_WIDTH   = 4;
    parameter int LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;
endpackage

module axi_wr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = axi_defs::ADDR_WIDTH,
    parameter int DATA_WIDTH  = axi_defs::DATA_WIDTH,
    parameter int ID_WIDTH    = axi_defs::ID_WIDTH,
    parameter int LEN_WIDTH   = axi_defs::LEN_WIDTH
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_MASTERS-1:0]            s_awvalid,
    output logic [NUM_MASTERS-1:0]            s_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_awid,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  s_awlen,
    input  logic [NUM_MASTERS*2-1:0]          s_awburst,
    input  logic [NUM_MASTERS-1:0]            s_wvalid,
    output logic [NUM_MASTERS-1:0]            s_wready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_MASTERS-1:0]            s_wlast,
    output logic [NUM_MASTERS-1:0]            s_bvalid,
    input  logic [NUM_MASTERS-1:0]            s_bready,
    output logic [NUM_MASTERS*2-1:0]          s_bresp,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]   s_bid,
    output logic                              m_awvalid,
    input  logic                              m_awready,
    output logic [ADDR_WIDTH-1:0]             m_awaddr,
    output logic [ID_WIDTH-1:0]               m_awid,
    output logic [LEN_WIDTH-1:0]              m_awlen,
    output logic [1:0]                        m_awburst,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    output logic [DATA_WIDTH-1:0]             m_wdata,
    output logic                              m_wlast,
    input  logic                              m_bvalid,
    output logic                              m_bready,
    input  logic [1:0]                        m_bresp,
    input  logic [ID_WIDTH-1:0]               m_bid,
    output logic                              busy,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_idx
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    ,
    output logic                              beat_err
`endif
);

    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [GW-1:0]        rr_ptr;
    logic [LEN_WIDTH:0]   beat_cnt;
    logic                 req_found;
    logic [GW-1:0]        req_idx;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 b_hs;

    assign busy = (state_q != IDLE);

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!req_found &&
                s_awvalid[(int'(rr_ptr) + i) % NUM_MASTERS]) begin
                req_found = 1'b1;
                req_idx   = GW'((int'(rr_ptr) + i) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        s_bid     = '0;
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_awid    = '0;
        m_awlen   = '0;
        m_awburst = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_found) state_d = ADDR;
            end
            ADDR: begin
                m_awvalid            = s_awvalid[grant_idx];
                s_awready[grant_idx] = m_awready;
                m_awaddr  = s_awaddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                m_awid    = s_awid[int'(grant_idx)*ID_WIDTH +: ID_WIDTH];
                m_awlen   = s_awlen[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
                m_awburst = s_awburst[int'(grant_idx)*2 +: 2];
                aw_hs     = m_awvalid && m_awready;
                if (aw_hs) state_d = DATA;
            end
            DATA: begin
                m_wvalid            = s_wvalid[grant_idx];
                s_wready[grant_idx] = m_wready;
                m_wdata = s_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                m_wlast = s_wlast[grant_idx];
                w_hs    = m_wvalid && m_wready;
                if (w_hs && m_wlast) state_d = RESP;
            end
            RESP: begin
                m_bready            = s_bready[grant_idx];
                s_bvalid[grant_idx] = m_bvalid;
                s_bresp[int'(grant_idx)*2 +: 2]              = m_bresp;
                s_bid[int'(grant_idx)*ID_WIDTH +: ID_WIDTH] = m_bid;
                b_hs = m_bvalid && m_bready;
                if (b_hs) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_found) grant_idx <= req_idx;
            if (aw_hs) beat_cnt <= '0;
            else if (w_hs) beat_cnt <= beat_cnt + (LEN_WIDTH+1)'(1);
            if (b_hs) begin
                rr_ptr <= (grant_idx == GW'(NUM_MASTERS-1)) ?
                          '0 : grant_idx + GW'(1);
            end
        end
    end

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    logic [LEN_WIDTH-1:0] awlen_q;
    logic                 beat_bad;

    // Early or missing WLAST relative to the latched AWLEN.
    assign beat_bad = w_hs &&
        (( m_wlast && (beat_cnt != {1'b0, awlen_q})) ||
         (!m_wlast && (beat_cnt == {1'b0, awlen_q})));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awlen_q  <= '0;
            beat_err <= 1'b0;
        end else begin
            if (aw_hs) awlen_q <= m_awlen;
            if (beat_bad) beat_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed self-checking bench for axi_wr_arbiter.
// Scenario tasks run in sequence; each checks its own expectations.
module tb_axi_wr_arbiter;
    import axi_defs::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int LW = 8;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      s_awvalid;
    logic [N-1:0]      s_awready;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*IW-1:0]   s_awid;
    logic [N*LW-1:0]   s_awlen;
    logic [N*2-1:0]    s_awburst;
    logic [N-1:0]      s_wvalid;
    logic [N-1:0]      s_wready;
    logic [N*DW-1:0]   s_wdata;
    logic [N-1:0]      s_wlast;
    logic [N-1:0]      s_bvalid;
    logic [N-1:0]      s_bready;
    logic [N*2-1:0]    s_bresp;
    logic [N*IW-1:0]   s_bid;
    logic              m_awvalid;
    logic              m_awready;
    logic [AW-1:0]     m_awaddr;
    logic [IW-1:0]     m_awid;
    logic [LW-1:0]     m_awlen;
    logic [1:0]        m_awburst;
    logic              m_wvalid;
    logic              m_wready;
    logic [DW-1:0]     m_wdata;
    logic              m_wlast;
    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;
    logic [IW-1:0]     m_bid;
    logic              busy;
    logic [0:0]        grant_idx;
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    logic              beat_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    axi_wr_arbiter #(.NUM_MASTERS(N)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bresp(s_bresp), .s_bid(s_bid),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bresp(m_bresp), .m_bid(m_bid),
        .busy(busy), .grant_idx(grant_idx)
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
        , .beat_err(beat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awid = '0;
        s_awlen = '0; s_awburst = '0;
        s_wvalid = '0; s_wdata = '0; s_wlast = '0;
        s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b0; m_bresp = '0; m_bid = '0;
    endtask

    task automatic apply_reset();
        init_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_aw(input int m, input logic [AW-1:0] a,
                          input logic [IW-1:0] id,
                          input logic [LW-1:0] len);
        s_awaddr[m*AW +: AW] = a;
        s_awid[m*IW +: IW]   = id;
        s_awlen[m*LW +: LW]  = len;
        s_awburst[m*2 +: 2]  = BURST_INCR;
        s_awvalid[m]         = 1'b1;
    endtask

    task automatic test_reset();
        init_inputs();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || grant_idx !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state busy=%b grant=%0d want 0 0",
                     busy, grant_idx);
        end
        n_checks++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 ||
            m_bready !== 1'b0 || s_awready !== 2'b00 ||
            s_wready !== 2'b00 || s_bvalid !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_hs awv=%b wv=%b br=%b awr=%b wr=%b bv=%b want all 0",
                     m_awvalid, m_wvalid, m_bready, s_awready,
                     s_wready, s_bvalid);
        end
        n_checks++;
        if (m_awaddr !== '0 || m_wdata !== '0 || s_bid !== '0) begin
            n_fails++;
            $display("FAIL reset_data awaddr=%h wdata=%h bid=%h want 0",
                     m_awaddr, m_wdata, s_bid);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        set_aw(0, 32'h1000, 4'd3, 8'd3);
        m_awready = 1'b1;
        #1;
        n_checks++;
        if (m_awvalid !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL single_idle awvalid=%b busy=%b want 0 0",
                     m_awvalid, busy);
        end
        tick();
        n_checks++;
        if (m_awvalid !== 1'b1 || m_awaddr !== 32'h1000 ||
            m_awid !== 4'd3 || m_awlen !== 8'd3 ||
            m_awburst !== 2'b01 || s_awready !== 2'b01 ||
            busy !== 1'b1 || grant_idx !== 1'b0) begin
            n_fails++;
            $display("FAIL single_aw v=%b a=%h id=%0d len=%0d rdy=%b g=%0d want 1 1000 3 3 01 0",
                     m_awvalid, m_awaddr, m_awid, m_awlen,
                     s_awready, grant_idx);
        end
        tick();
        s_awvalid = '0;
        m_awready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_wvalid[0] = 1'b1;
            s_wdata[0 +: DW] = 32'h100 + b;
            s_wlast[0] = (b == 3);
            m_wready = 1'b1;
            #1;
            n_checks++;
            if (m_wvalid !== 1'b1 || m_wdata !== 32'h100 + b ||
                m_wlast !== (b == 3) || s_wready !== 2'b01) begin
                n_fails++;
                $display("FAIL single_w%0d v=%b d=%h last=%b rdy=%b want 1 %h %b 01",
                         b, m_wvalid, m_wdata, m_wlast, s_wready,
                         32'h100 + b, b == 3);
            end
            tick();
        end
        s_wlast = '0;
        m_bvalid = 1'b1;
        m_bresp = RESP_OKAY;
        m_bid = 4'd3;
        s_bready = 2'b01;
        #1;
        n_checks++;
        if (m_wvalid !== 1'b0 || s_wready !== 2'b00 ||
            s_bvalid !== 2'b01 || s_bresp !== 4'b0000 ||
            s_bid !== 8'h03 || m_bready !== 1'b1) begin
            n_fails++;
            $display("FAIL single_b wv=%b wr=%b bv=%b resp=%b bid=%h br=%b want 0 00 01 0000 03 1",
                     m_wvalid, s_wready, s_bvalid, s_bresp, s_bid,
                     m_bready);
        end
        tick();
        init_inputs();
        #1;
        n_checks++;
        if (busy !== 1'b0 || s_bvalid !== 2'b00) begin
            n_fails++;
            $display("FAIL single_done busy=%b bv=%b want 0 00",
                     busy, s_bvalid);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        set_aw(0, 32'h2000, 4'd1, 8'd0);
        set_aw(1, 32'h3000, 4'd5, 8'd1);
        m_awready = 1'b1;
        tick();
        n_checks++;
        if (grant_idx !== 1'b0 || s_awready !== 2'b01 ||
            m_awaddr !== 32'h2000) begin
            n_fails++;
            $display("FAIL cont_first g=%0d rdy=%b a=%h want 0 01 2000",
                     grant_idx, s_awready, m_awaddr);
        end
        tick();
        s_awvalid[0] = 1'b0;
        s_wvalid = 2'b11;
        s_wdata = {32'hBBBB_0000, 32'hAAAA_0000};
        s_wlast = 2'b11;
        m_wready = 1'b1;
        #1;
        n_checks++;
        if (s_wready !== 2'b01 || m_wdata !== 32'hAAAA_0000) begin
            n_fails++;
            $display("FAIL cont_w0 rdy=%b d=%h want 01 aaaa0000",
                     s_wready, m_wdata);
        end
        tick();
        s_wvalid = '0;
        m_bvalid = 1'b1;
        m_bresp = RESP_SLVERR;
        m_bid = 4'd1;
        s_bready = 2'b11;
        #1;
        n_checks++;
        if (s_bvalid !== 2'b01 || s_bresp !== 4'b0010 ||
            s_bid !== 8'h01) begin
            n_fails++;
            $display("FAIL cont_b0 bv=%b resp=%b bid=%h want 01 0010 01",
                     s_bvalid, s_bresp, s_bid);
        end
        tick();
        m_bvalid = 1'b0;
        set_aw(0, 32'h4000, 4'd2, 8'd0);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL cont_idle busy=%b want 0", busy);
        end
        tick();
        n_checks++;
        if (grant_idx !== 1'b1 || m_awaddr !== 32'h3000 ||
            s_awready !== 2'b10) begin
            n_fails++;
            $display("FAIL cont_second g=%0d a=%h rdy=%b want 1 3000 10",
                     grant_idx, m_awaddr, s_awready);
        end
        tick();
        s_awvalid[1] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_wvalid = 2'b11;
            s_wdata[DW +: DW] = 32'hBBBB_0000 + b;
            s_wlast = {b == 1, 1'b1};
            #1;
            n_checks++;
            if (s_wready !== 2'b10 ||
                m_wdata !== 32'hBBBB_0000 + b) begin
                n_fails++;
                $display("FAIL cont_w1_%0d rdy=%b d=%h want 10 %h",
                         b, s_wready, m_wdata, 32'hBBBB_0000 + b);
            end
            tick();
        end
        s_wvalid = '0;
        m_bvalid = 1'b1;
        m_bresp = RESP_OKAY;
        m_bid = 4'd5;
        #1;
        n_checks++;
        if (s_bvalid !== 2'b10 || s_bid !== 8'h50 ||
            m_awvalid !== 1'b0 || s_awready !== 2'b00) begin
            n_fails++;
            $display("FAIL cont_b1 bv=%b bid=%h awv=%b awr=%b want 10 50 0 00",
                     s_bvalid, s_bid, m_awvalid, s_awready);
        end
        tick();
        m_bvalid = 1'b0;
        tick();
        n_checks++;
        if (grant_idx !== 1'b0 || m_awaddr !== 32'h4000 ||
            m_awvalid !== 1'b1) begin
            n_fails++;
            $display("FAIL cont_third g=%0d a=%h v=%b want 0 4000 1",
                     grant_idx, m_awaddr, m_awvalid);
        end
    endtask

    task automatic test_backpressure();
        int beat;
        apply_reset();
        set_aw(1, 32'h5000, 4'd7, 8'd7);
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        m_awready = 1'b0;
        beat = 0;
        for (int c = 0; c < 20 && beat < 8; c++) begin
            s_wvalid[1] = 1'b1;
            s_wdata[DW +: DW] = 32'hA0 + beat;
            s_wlast[1] = (beat == 7);
            m_wready = (c % 2 == 0);
            #1;
            n_checks++;
            if (m_wvalid !== 1'b1 || m_wdata !== 32'hA0 + beat ||
                m_wlast !== (beat == 7) ||
                s_wready !== {m_wready, 1'b0}) begin
                n_fails++;
                $display("FAIL bp_w c=%0d v=%b d=%h last=%b rdy=%b want 1 %h %b %b",
                         c, m_wvalid, m_wdata, m_wlast, s_wready,
                         32'hA0 + beat, beat == 7, {m_wready, 1'b0});
            end
            if (m_wready) beat++;
            tick();
        end
        n_checks++;
        if (beat !== 8) begin
            n_fails++;
            $display("FAIL bp_beats got=%0d want 8", beat);
        end
        s_wvalid = '0;
        s_wlast = '0;
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        m_bresp = RESP_EXOKAY;
        m_bid = 4'd7;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (m_bready !== 1'b0 || s_bvalid !== 2'b10 ||
                grant_idx !== 1'b1 || busy !== 1'b1) begin
                n_fails++;
                $display("FAIL bp_bhold c=%0d br=%b bv=%b g=%0d busy=%b want 0 10 1 1",
                         c, m_bready, s_bvalid, grant_idx, busy);
            end
            tick();
        end
        s_bready[1] = 1'b1;
        #1;
        n_checks++;
        if (m_bready !== 1'b1 || s_bresp !== 4'b0100 ||
            s_bid !== 8'h70) begin
            n_fails++;
            $display("FAIL bp_b br=%b resp=%b bid=%h want 1 0100 70",
                     m_bready, s_bresp, s_bid);
        end
        tick();
        init_inputs();
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_done busy=%b want 0", busy);
        end
    endtask

    task automatic test_early_w();
        apply_reset();
        s_wvalid[1] = 1'b1;
        s_wdata[DW +: DW] = 32'hDEAD_BEEF;
        s_wlast[1] = 1'b1;
        m_wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (s_wready !== 2'b00 || m_wvalid !== 1'b0) begin
                n_fails++;
                $display("FAIL early_idle c=%0d wr=%b wv=%b want 00 0",
                         c, s_wready, m_wvalid);
            end
            tick();
        end
        set_aw(1, 32'h6000, 4'd9, 8'd0);
        tick();
        m_awready = 1'b1;
        #1;
        n_checks++;
        if (s_wready !== 2'b00 || m_wvalid !== 1'b0 ||
            m_awvalid !== 1'b1 || s_awready !== 2'b10) begin
            n_fails++;
            $display("FAIL early_addr wr=%b wv=%b awv=%b awr=%b want 00 0 1 10",
                     s_wready, m_wvalid, m_awvalid, s_awready);
        end
        tick();
        s_awvalid = '0;
        #1;
        n_checks++;
        if (s_wready !== 2'b10 || m_wvalid !== 1'b1 ||
            m_wdata !== 32'hDEAD_BEEF || m_wlast !== 1'b1) begin
            n_fails++;
            $display("FAIL early_data wr=%b wv=%b d=%h last=%b want 10 1 deadbeef 1",
                     s_wready, m_wvalid, m_wdata, m_wlast);
        end
        tick();
        s_wvalid = '0;
        m_bvalid = 1'b1;
        s_bready = 2'b10;
        tick();
        init_inputs();
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL early_done busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_aw(0, 32'h7000, 4'd1, 8'd0);
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        s_wvalid[0] = 1'b1;
        s_wlast[0] = 1'b1;
        m_wready = 1'b1;
        tick();
        s_wvalid = '0;
        m_bvalid = 1'b1;
        s_bready = 2'b01;
        tick();
        init_inputs();
        set_aw(0, 32'h8000, 4'd2, 8'd3);
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid = '0;
        for (int b = 0; b < 2; b++) begin
            s_wvalid[0] = 1'b1;
            s_wdata[0 +: DW] = 32'hC0 + b;
            m_wready = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant_idx !== 1'b0 ||
            m_wvalid !== 1'b0 || s_wready !== 2'b00 ||
            m_wdata !== '0 || m_awvalid !== 1'b0) begin
            n_fails++;
            $display("FAIL rmid_async busy=%b g=%0d wv=%b wr=%b d=%h awv=%b want 0 0 0 00 0 0",
                     busy, grant_idx, m_wvalid, s_wready, m_wdata,
                     m_awvalid);
        end
        tick();
        init_inputs();
        rst_n = 1'b1;
        tick();
        set_aw(0, 32'h9000, 4'd4, 8'd0);
        set_aw(1, 32'h9100, 4'd6, 8'd0);
        tick();
        n_checks++;
        if (grant_idx !== 1'b0 || m_awvalid !== 1'b1 ||
            m_awaddr !== 32'h9000) begin
            n_fails++;
            $display("FAIL rmid_regrant g=%0d v=%b a=%h want 0 1 9000",
                     grant_idx, m_awvalid, m_awaddr);
        end
    endtask

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
    task automatic test_beat_check();
        apply_reset();
        n_checks++;
        if (beat_err !== 1'b0) begin
            n_fails++;
            $display("FAIL bchk_reset beat_err=%b want 0", beat_err);
        end
        for (int t = 0; t < 3; t++) begin
            set_aw(0, 32'hA000, 4'd1, 8'd3);
            m_awready = 1'b1;
            tick();
            tick();
            s_awvalid = '0;
            m_awready = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (t != 1 || b < 2) begin
                    s_wvalid[0] = 1'b1;
                    s_wlast[0] = (t == 1) ? (b == 1) : (b == 3);
                    m_wready = 1'b1;
                    tick();
                end
            end
            s_wvalid = '0;
            s_wlast = '0;
            m_wready = 1'b0;
            #1;
            n_checks++;
            if (beat_err !== (t != 0) || s_bvalid !== 2'b00 ||
                busy !== 1'b1) begin
                n_fails++;
                $display("FAIL bchk_t%0d beat_err=%b bv=%b busy=%b want %b 00 1",
                         t, beat_err, s_bvalid, busy, t != 0);
            end
            m_bvalid = 1'b1;
            s_bready = 2'b01;
            #1;
            n_checks++;
            if (s_bvalid !== 2'b01) begin
                n_fails++;
                $display("FAIL bchk_resp_t%0d bv=%b want 01", t, s_bvalid);
            end
            tick();
            init_inputs();
            tick();
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        init_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_w();
        test_reset_mid();
`ifdef AXI_WR_ARB_BEAT_CHECK_EN
        test_beat_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
